pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-request controller for the Tomasulo front end.
- Issues one instruction-fetch request at a time to the I-cache over a valid/ready handshake.
- Advances the PC by the decoder-supplied offset.
- When the offset depends on an unresolved register, blocks on a lock tag until the matching CDB broadcast arrives.
- Accepts a flush redirect from the ROB, which has priority over everything else.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_lock_tracker.sv | 74 +++++++
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the PC / fetch-request controller.
package pc_pkg;

    typedef enum logic [1:0] {BOOT, RUN, WAIT_DEC, WAIT_CDB} pc_state_e;

    // Project-wide "no dependency" tag value.
    localparam int PROJ_NO_LOCK = 0;

    // Mask that clears the low log2(inst_bytes) bits; inst_bytes must be a power of two.
    function automatic logic [63:0] align_mask(input int inst_bytes);
        return ~(64'(inst_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_lock_tracker.sv
// Holds the tag the next PC waits on, matches CDB broadcasts (including the
// same-cycle bypass at decode) and counts cycles spent waiting.
module pc_lock_tracker
    import pc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LOCK_W  = 5,
    parameter int NO_LOCK = PROJ_NO_LOCK,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_wait_dec,
    input  logic              redirect,
    input  logic              dec_valid,
    input  logic [LOCK_W-1:0] dec_lock,
    input  logic              cdb_valid,
    input  logic [LOCK_W-1:0] cdb_tag,
    input  logic [ADDR_W-1:0] cdb_result,
    output logic              resolve,
    output logic [ADDR_W-1:0] resolve_offset,
    output logic              lock_busy,
    output logic [LOCK_W-1:0] cur_lock,
    output logic [CNT_W-1:0]  lock_wait_cnt
);

    localparam logic [LOCK_W-1:0] NO_TAG = LOCK_W'(NO_LOCK);

    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dec_locked, bypass_hit, wait_hit, enter_wait;

    assign dec_locked = in_wait_dec && dec_valid && (dec_lock != NO_TAG);
    assign bypass_hit = dec_locked && cdb_valid && (cdb_tag == dec_lock);
    assign wait_hit   = busy_q && cdb_valid && (cdb_tag == lock_q);
    assign enter_wait = dec_locked && !bypass_hit && !redirect;

    // A redirect in the same cycle drops any match.
    assign resolve        = (bypass_hit || wait_hit) && !redirect;
    assign resolve_offset = cdb_result;

    always_comb begin
        lock_d = lock_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (busy_q && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        if (redirect || (busy_q && wait_hit)) begin
            lock_d = NO_TAG;
            busy_d = 1'b0;
        end else if (enter_wait) begin
            lock_d = dec_lock;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q <= NO_TAG;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_busy     = busy_q;
    assign cur_lock      = lock_q;
    assign lock_wait_cnt = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding fetch-request controller with
// lock/CDB dependency handling and ROB redirect.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                LOCK_W     = 5,
    parameter int                NO_LOCK    = PROJ_NO_LOCK,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic              if_req_valid,
    output logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_req_ready,
    input  logic              dec_valid,
    input  logic [LOCK_W-1:0] dec_lock,
    input  logic [ADDR_W-1:0] dec_offset,
    input  logic              cdb_valid,
    input  logic [LOCK_W-1:0] cdb_tag,
    input  logic [ADDR_W-1:0] cdb_result,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              lock_busy,
    output logic [LOCK_W-1:0] cur_lock,
    output logic [CNT_W-1:0]  lock_wait_cnt
);

    localparam logic [63:0]       MASK64     = align_mask(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = MASK64[ADDR_W-1:0];
    localparam logic [LOCK_W-1:0] NO_TAG     = LOCK_W'(NO_LOCK);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              vld_q, vld_d;
    logic              resolve;
    logic [ADDR_W-1:0] resolve_offset;
    logic              plain_dec;

    pc_lock_tracker #(
        .ADDR_W (ADDR_W),
        .LOCK_W (LOCK_W),
        .NO_LOCK(NO_LOCK),
        .CNT_W  (CNT_W)
    ) u_lock (
        .clk           (clk),
        .rst           (rst),
        .in_wait_dec   (state_q == WAIT_DEC),
        .redirect      (redirect_valid),
        .dec_valid     (dec_valid),
        .dec_lock      (dec_lock),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_result    (cdb_result),
        .resolve       (resolve),
        .resolve_offset(resolve_offset),
        .lock_busy     (lock_busy),
        .cur_lock      (cur_lock),
        .lock_wait_cnt (lock_wait_cnt)
    );

    assign plain_dec = (state_q == WAIT_DEC) && dec_valid && (dec_lock == NO_TAG);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            vld_d   = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (vld_q) begin
                        if (if_req_ready) begin
                            vld_d   = 1'b0;
                            state_d = WAIT_DEC;
                        end
                    end else if (!stall) begin
                        vld_d = 1'b1;
                    end
                end
                WAIT_DEC, WAIT_CDB: begin
                    // Raise the next request on the same edge that updates pc.
                    if (plain_dec || resolve) begin
                        pc_d    = (pc_q + (plain_dec ? dec_offset : resolve_offset)) & ALIGN_MASK;
                        state_d = RUN;
                        vld_d   = !stall;
                    end else if (state_q == WAIT_DEC && dec_valid) begin
                        state_d = WAIT_CDB;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
        end
    end

    assign if_req_valid = vld_q;
    assign if_req_addr  = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboarded bench for pc_fetch_ctrl: expected fetch addresses are queued
// as stimulus is driven and compared at each accepted request.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready = 1'b1;
    logic        dec_valid = 1'b0;
    logic [4:0]  dec_lock = '0;
    logic [31:0] dec_offset = '0;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_result = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        lock_busy;
    logic [4:0]  cur_lock;
    logic [15:0] lock_wait_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .dec_valid     (dec_valid),
        .dec_lock      (dec_lock),
        .dec_offset    (dec_offset),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_result    (cdb_result),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .lock_busy     (lock_busy),
        .cur_lock      (cur_lock),
        .lock_wait_cnt (lock_wait_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Accepted requests are compared against the scoreboard.
    always @(negedge clk) begin
        if (rst && if_req_valid && if_req_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(if_req_addr), 32'hDEAD_BEEF);
            else                   chk("sb_addr", if_req_addr, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!if_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!if_req_valid) chk("wait_valid_timeout", 32'(if_req_valid), 1);
    endtask

    task automatic dec_drive(input logic [4:0] lock, input logic [31:0] off,
                             input logic byp, input logic [31:0] res);
        dec_valid = 1'b1; dec_lock = lock; dec_offset = off;
        cdb_valid = byp; cdb_tag = lock; cdb_result = res;
        tick();
        dec_valid = 1'b0; dec_lock = '0; dec_offset = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    endtask

    // Let the current request be accepted, then answer it from the decoder.
    task automatic issue_dec(input logic [4:0] lock, input logic [31:0] off,
                             input logic byp, input logic [31:0] res, input logic rdy_after);
        wait_valid();
        tick();
        if_req_ready = rdy_after;
        dec_drive(lock, off, byp, res);
    endtask

    task automatic plain(input logic [31:0] off);
        model_pc = (model_pc + off) & 32'hFFFF_FFFC;
        exp_q.push_back(model_pc);
        issue_dec(5'd0, off, 1'b0, 32'd0, 1'b1);
        chk("cadence_valid", 32'(if_req_valid), 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_valid", 32'(if_req_valid), 0);
        chk("rst_addr", if_req_addr, 0);
        chk("rst_busy", 32'(lock_busy), 0);
        chk("rst_lock", 32'(cur_lock), 0);
        chk("rst_cnt", 32'(lock_wait_cnt), 0);
        rst = 1'b1;
        model_pc = 0;
        exp_q.push_back(0);
        tick();
        chk("boot_no_req", 32'(if_req_valid), 0);

        // Straight-line fetch: 0x0, 0x4, 0x8, then on to 0x10
        plain(32'd4);
        plain(32'd4);
        plain(32'd4);
        plain(32'd4);
        chk("t1_addr10", if_req_addr, 32'h10);

        // Locked offset resolved by CDB after non-matching traffic
        issue_dec(5'd3, 32'h99, 1'b0, 32'd0, 1'b1);
        chk("t2_busy1", 32'(lock_busy), 1);
        chk("t2_lock", 32'(cur_lock), 3);
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_result = 32'h55;
        tick();
        cdb_valid = 1'b0;
        chk("t2_busy2", 32'(lock_busy), 1);
        tick();
        chk("t2_busy3", 32'(lock_busy), 1);
        model_pc = 32'h30;
        exp_q.push_back(model_pc);
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_result = 32'h20;
        tick();
        cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
        chk("t2_busy_clr", 32'(lock_busy), 0);
        chk("t2_lock_clr", 32'(cur_lock), 0);
        chk("t2_cnt", 32'(lock_wait_cnt), 3);
        chk("t2_valid", 32'(if_req_valid), 1);
        chk("t2_addr", if_req_addr, 32'h30);

        // Same-cycle bypass with a negative offset
        plain(32'h10);
        model_pc = 32'h38;
        exp_q.push_back(model_pc);
        issue_dec(5'd7, 32'h1234, 1'b1, 32'hFFFF_FFF8, 1'b1);
        chk("t3_no_wait", 32'(lock_busy), 0);
        chk("t3_valid", 32'(if_req_valid), 1);
        chk("t3_addr", if_req_addr, 32'h38);
        chk("t3_cnt", 32'(lock_wait_cnt), 3);

        // Held request under back-pressure, then stall in RUN
        model_pc = 32'h100;
        exp_q.push_back(model_pc);
        issue_dec(5'd0, 32'hC8, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            tick();
            chk("t4_hold_valid", 32'(if_req_valid), 1);
            chk("t4_hold_addr", if_req_addr, 32'h100);
        end
        if_req_ready = 1'b1;
        stall = 1'b1;
        tick();
        model_pc = 32'h104;
        exp_q.push_back(model_pc);
        dec_drive(5'd0, 32'd4, 1'b0, 32'd0);
        chk("t4_stall_a", 32'(if_req_valid), 0);
        tick();
        chk("t4_stall_b", 32'(if_req_valid), 0);
        stall = 1'b0;
        tick();
        chk("t4_unstall", 32'(if_req_valid), 1);
        chk("t4_addr", if_req_addr, 32'h104);

        // Redirect beats a simultaneous CDB match
        issue_dec(5'd2, 32'h77, 1'b0, 32'd0, 1'b1);
        chk("t5_busy", 32'(lock_busy), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_result = 32'h40;
        tick();
        redirect_valid = 1'b0; redirect_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
        chk("t5_busy_clr", 32'(lock_busy), 0);
        chk("t5_lock_clr", 32'(cur_lock), 0);
        chk("t5_valid0", 32'(if_req_valid), 0);
        chk("t5_pc", if_req_addr, 32'h200);
        chk("t5_cnt", 32'(lock_wait_cnt), 4);
        model_pc = 32'h200;
        exp_q.push_back(model_pc);
        tick();
        chk("t5_valid1", 32'(if_req_valid), 1);

        // Reset in WAIT_CDB, then PC wraparound
        issue_dec(5'd9, 32'h10, 1'b0, 32'd0, 1'b1);
        chk("t6_busy", 32'(lock_busy), 1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(if_req_valid), 0);
        chk("t6_rst_addr", if_req_addr, 0);
        chk("t6_rst_busy", 32'(lock_busy), 0);
        chk("t6_rst_lock", 32'(cur_lock), 0);
        chk("t6_rst_cnt", 32'(lock_wait_cnt), 0);
        rst = 1'b1;
        model_pc = 0;
        exp_q.push_back(0);
        plain(32'hFFFF_FFFC);
        chk("t6_addr_top", if_req_addr, 32'hFFFF_FFFC);
        plain(32'd8);
        chk("t6_wrap", if_req_addr, 32'h4);
        tick();
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
